rs_decode: RTL and testbench
============================

// Module: rs_decode
// PURPOSE
//  RS(15,9) decoder over GF(16) (prime poly x^4+x+1, roots a^1..a^6, fcr=1), the receive-side peer of the RS(15,9) encoder.
//  Takes a 60-bit codeword and computes 6 syndromes serially (Horner, 15 cycles).
//  Corrects any single-symbol error; flags 2..3-symbol errors as uncorrectable. Returns the 36-bit information field.
// PARAMETERS
//  WORD_WIDTH  4   symbol width (fixed; do not override)
//  K_NUM       9   information symbols
//  N_NUM       15  codeword symbols
// PORTS
//  clk        in   1   clock
//  rst_n      in   1   reset, synchronous, active-low
//  data_en    in   1   start; rising edge captures codein
//  codein     in   60  codeword; bits [4k+3:4k] = coeff of x^k; [59:56] = first data symbol, [3:0] = last parity
//  busy       out  1   decode in progress
//  data_rdy   out  1   dataout/flags valid
//  dataout    out  36  corrected info symbols (codeword bits [59:24])
//  err_det    out  1   nonzero syndrome seen
//  err_fix    out  1   single error corrected
//  err_fail   out  1   uncorrectable; dataout = uncorrected codein[59:24]
//  err_pos    out  4   degree j of the corrected symbol (0..14); 0 unless err_fix
// BEHAVIOUR
//  - Reset: all outputs 0, syndromes 0, FSM=IDLE. Reset mid-operation aborts the decode; no data_rdy.
//  - Start: data_en=1 with registered data_en=0 (edge T0). Captures codein into shift_code.
//    Sets busy=1, clears data_rdy/err_*. Edges of data_en while busy=1 are ignored.
//  - FSM IDLE -> SYND -> LOCATE -> CHECK -> DONE -> IDLE.
//  - SYND, edges T1..T15: r = shift_code[59:56]; for i=1..6: S_i <= S_i*a^i ^ r; shift_code rotates left 4 bits.
//    After T15: S_i = r(a^i) and shift_code is restored.
//  - LOCATE, T16:
//    - All S_i==0: clean.
//    - Else S1==0 or S2==0: fail.
//    - Else X <= S2*inv(S1), E <= S1*S1*inv(S2).
//  - CHECK, T17: fail unless S_{i+1}==S_i*X for i=2..5. On pass: j=log(X); fix.
//  - DONE, T18: dataout <= shift_code[59:24] ^ (E placed at symbol j if fix and j>=6).
//    Sets err flags; err_det = fix|fail. busy <= 0, data_rdy <= 1.
//  - Latency: data_rdy rises 18 clocks after the capture edge.
//  - Parity-symbol error (j<6): err_fix=1, err_pos=j, dataout unchanged.
//  - Outputs hold until the next capture edge, which clears data_rdy and err_*.
//  - A start on the same edge as DONE is ignored (busy still 1).
//  - GF arithmetic: add = XOR; mul = carry-less product mod x^4+x+1; inv(0)=0 (never used, guarded by zero checks).
// STRUCTURE
//  - Shared include rs15_9_defs.vh holds:
//    - WORD_WIDTH/K_NUM/N_NUM and the prime poly;
//    - constants A_1DEGREE..A_6DEGREE (0010,0100,1000,0011,0110,1100);
//    - 16-entry GF inverse and log tables; FSM state codes.
//  - Multipliers reuse gf2_3mult, adders reuse gf2_add.
//  - Sub-module rs_syndrome: 6 Horner lanes, ports clk/rst_n/clr/en/sym[3:0]/synd[23:0]. Parent holds FSM, locate/check, correction.
// TESTING
//  - Clean zero: codein=0 -> T18 data_rdy=1, dataout=0, err_det=0, err_fix=0, err_fail=0.
//  - Clean all-F: codein=60'hFFF..F (constant codeword) -> dataout=36'hFFFFFFFFF, no flags.
//  - Single data error: codein=0 ^ (4'h5<<40) -> dataout=0, err_fix=1, err_pos=10, err_det=1.
//  - Encoder loopback: rs_encode(36'h123456789), bits [3:0] ^= 4'hA -> dataout=36'h123456789, err_fix=1, err_pos=0.
//    Repeat with every degree 0..14 and every nonzero error value.
//  - Double error: codein=0 with bit 56 and bit 0 set -> err_fail=1, err_fix=0, dataout=36'h100000000.
//    Random 2- and 3-symbol errors on loopback words -> always err_fail.
//  - Control:
//    - data_en re-pulsed at T5 is ignored; result still at T18.
//    - rst_n=0 at T9 -> busy=0, data_rdy=0, no result.
//    - Next start after DONE clears data_rdy on the capture edge.

Source files
------------

// File: rtl/rs_decode_pkg.sv
// Shared RS(15,9) over GF(16) definitions: field constants, lookup tables, FSM states.
package rs_decode_pkg;
  localparam int WORD_WIDTH = 4;
  localparam int K_NUM      = 9;
  localparam int N_NUM      = 15;
  localparam int PAR_NUM    = N_NUM - K_NUM;

  localparam logic [4:0] PRIME_POLY = 5'b10011;

  localparam logic [3:0] A_1DEGREE = 4'b0010;
  localparam logic [3:0] A_2DEGREE = 4'b0100;
  localparam logic [3:0] A_3DEGREE = 4'b1000;
  localparam logic [3:0] A_4DEGREE = 4'b0011;
  localparam logic [3:0] A_5DEGREE = 4'b0110;
  localparam logic [3:0] A_6DEGREE = 4'b1100;
  localparam logic [23:0] A_DEGREES = {A_6DEGREE, A_5DEGREE, A_4DEGREE,
                                       A_3DEGREE, A_2DEGREE, A_1DEGREE};

  typedef enum logic [2:0] {ST_IDLE, ST_SYND, ST_LOCATE, ST_CHECK, ST_DONE} state_t;

  function automatic logic [3:0] gf2_add(input logic [3:0] a, input logic [3:0] b);
    return a ^ b;
  endfunction

  // Carry-less product followed by reduction modulo x^4+x+1.
  function automatic logic [3:0] gf2_3mult(input logic [3:0] a, input logic [3:0] b);
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 4; i++)
      if (b[i]) p = p ^ ({3'b000, a} << i);
    for (int i = 6; i >= 4; i--)
      if (p[i]) p = p ^ ({2'b00, PRIME_POLY} << (i - 4));
    return p[3:0];
  endfunction

  function automatic logic [3:0] gf_inv(input logic [3:0] a);
    case (a)
      4'h1: return 4'h1;  4'h2: return 4'h9;  4'h3: return 4'hE;  4'h4: return 4'hD;
      4'h5: return 4'hB;  4'h6: return 4'h7;  4'h7: return 4'h6;  4'h8: return 4'hF;
      4'h9: return 4'h2;  4'hA: return 4'hC;  4'hB: return 4'h5;  4'hC: return 4'hA;
      4'hD: return 4'h4;  4'hE: return 4'h3;  4'hF: return 4'h8;  default: return 4'h0;
    endcase
  endfunction

  function automatic logic [3:0] gf_log(input logic [3:0] a);
    case (a)
      4'h2: return 4'd1;   4'h3: return 4'd4;   4'h4: return 4'd2;   4'h5: return 4'd8;
      4'h6: return 4'd5;   4'h7: return 4'd10;  4'h8: return 4'd3;   4'h9: return 4'd14;
      4'hA: return 4'd9;   4'hB: return 4'd7;   4'hC: return 4'd6;   4'hD: return 4'd13;
      4'hE: return 4'd11;  4'hF: return 4'd12;  default: return 4'd0;
    endcase
  endfunction
endpackage

// File: rtl/rs_decode_syndrome.sv
// Six Horner lanes: each step S_i <= S_i*a^i + r, so after 15 symbols S_i = r(a^i).
module rs_syndrome
  import rs_decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [3:0]  sym,
  output logic [23:0] synd
);
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      synd <= '0;
    end else if (en) begin
      for (int i = 0; i < PAR_NUM; i++)
        synd[4*i +: 4] <= gf2_add(gf2_3mult(synd[4*i +: 4], A_DEGREES[4*i +: 4]), sym);
    end
  end
endmodule

// File: rtl/rs_decode.sv
// RS(15,9) single-symbol-correcting decoder: serial syndromes, then locate/check/correct.
module rs_decode
  import rs_decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_en,
  input  logic [59:0] codein,
  output logic        busy,
  output logic        data_rdy,
  output logic [35:0] dataout,
  output logic        err_det,
  output logic        err_fix,
  output logic        err_fail,
  output logic [3:0]  err_pos
);
  state_t      state;
  logic [3:0]  cnt;
  logic [59:0] shift_code;
  logic        data_en_q;
  logic        start;
  logic [23:0] synd;
  logic [3:0]  s [PAR_NUM];
  logic [3:0]  x_loc, e_val, j_pos;
  logic        loc_clean, loc_fail, fix, fail;
  logic        chk_ok;
  logic [5:0]  corr_sh;
  logic [35:0] corr;

  assign start = data_en && !data_en_q && !busy;

  rs_syndrome u_synd (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .en    (state == ST_SYND),
    .sym   (shift_code[59:56]),
    .synd  (synd)
  );

  always_comb begin
    for (int i = 0; i < PAR_NUM; i++) s[i] = synd[4*i +: 4];
  end

  // A genuine single error makes the syndromes a geometric sequence with ratio X.
  always_comb begin
    chk_ok = 1'b1;
    for (int i = 1; i < PAR_NUM - 1; i++)
      if (s[i+1] != gf2_3mult(s[i], x_loc)) chk_ok = 1'b0;
  end

  always_comb begin
    corr_sh = {j_pos - 4'd6, 2'b00};
    corr    = '0;
    if (fix && j_pos >= 4'(PAR_NUM)) corr = {32'd0, e_val} << corr_sh;
  end

  always_ff @(posedge clk) begin
    if (start) shift_code <= codein;
    else if (state == ST_SYND) shift_code <= {shift_code[55:0], shift_code[59:56]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      data_en_q <= 1'b0;
      busy      <= 1'b0;
      data_rdy  <= 1'b0;
      dataout   <= '0;
      err_det   <= 1'b0;
      err_fix   <= 1'b0;
      err_fail  <= 1'b0;
      err_pos   <= '0;
      x_loc     <= '0;
      e_val     <= '0;
      j_pos     <= '0;
      loc_clean <= 1'b0;
      loc_fail  <= 1'b0;
      fix       <= 1'b0;
      fail      <= 1'b0;
    end else begin
      data_en_q <= data_en;
      case (state)
        ST_IDLE: if (start) begin
          busy     <= 1'b1;
          data_rdy <= 1'b0;
          err_det  <= 1'b0;
          err_fix  <= 1'b0;
          err_fail <= 1'b0;
          err_pos  <= '0;
          cnt      <= '0;
          state    <= ST_SYND;
        end
        ST_SYND: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'(N_NUM - 1)) state <= ST_LOCATE;
        end
        ST_LOCATE: begin
          loc_clean <= (synd == '0);
          loc_fail  <= (synd != '0) && (s[0] == '0 || s[1] == '0);
          x_loc     <= gf2_3mult(s[1], gf_inv(s[0]));
          e_val     <= gf2_3mult(gf2_3mult(s[0], s[0]), gf_inv(s[1]));
          state     <= ST_CHECK;
        end
        ST_CHECK: begin
          fix   <= !loc_clean && !loc_fail && chk_ok;
          fail  <= loc_fail || (!loc_clean && !chk_ok);
          j_pos <= gf_log(x_loc);
          state <= ST_DONE;
        end
        ST_DONE: begin
          dataout  <= shift_code[59:24] ^ corr;
          err_det  <= fix || fail;
          err_fix  <= fix;
          err_fail <= fail;
          err_pos  <= fix ? j_pos : 4'd0;
          busy     <= 1'b0;
          data_rdy <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rs_decode.sv
// Bench for rs_decode: GF(16) via exp/log tables, systematic RS(15,9) encoder model, injected errors.
module tb_rs_decode;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        data_en;
  logic [59:0] codein;
  logic        busy, data_rdy, err_det, err_fix, err_fail;
  logic [35:0] dataout;
  logic [3:0]  err_pos;

  int n_cmp = 0;
  int n_bad = 0;
  int gexp [30];
  int glog [16];
  int gen  [7];

  rs_decode dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_en  (data_en),
    .codein   (codein),
    .busy     (busy),
    .data_rdy (data_rdy),
    .dataout  (dataout),
    .err_det  (err_det),
    .err_fix  (err_fix),
    .err_fail (err_fail),
    .err_pos  (err_pos)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return gexp[glog[a] + glog[b]];
  endfunction

  // Systematic encoding: parity = x^6*m(x) mod g(x), g(x) = prod (x - a^i), i=1..6.
  function automatic logic [59:0] encode(input logic [35:0] info);
    int rem [6];
    int fb;
    logic [59:0] cw;
    for (int t = 0; t < 6; t++) rem[t] = 0;
    for (int k = 8; k >= 0; k--) begin
      fb = int'(info[4*k +: 4]) ^ rem[5];
      for (int t = 5; t >= 1; t--) rem[t] = rem[t-1] ^ gmul(fb, gen[t]);
      rem[0] = gmul(fb, gen[0]);
    end
    cw = {info, 24'd0};
    for (int t = 0; t < 6; t++) cw[4*t +: 4] = 4'(rem[t]);
    return cw;
  endfunction

  // One decode; rep_at raises data_en for the single edge T<rep_at> while busy.
  task automatic run(input logic [59:0] code, input logic [35:0] exp_data, input logic exp_fix,
                     input logic exp_fail, input logic [3:0] exp_pos, input int rep_at, input string tag);
    int n;
    @(negedge clk);
    codein  = code;
    data_en = 1'b1;
    @(posedge clk); #1;
    check({tag, "/busy_at_T0"}, 64'(busy), 64'd1);
    check({tag, "/rdy_clr_T0"}, 64'({data_rdy, err_det, err_fix, err_fail}), 64'd0);
    @(negedge clk);
    data_en = 1'b0;
    n = 0;
    while (n < 30 && data_rdy !== 1'b1) begin
      data_en = (n + 1 == rep_at);
      @(posedge clk); #1;
      n++;
    end
    data_en = 1'b0;
    check({tag, "/latency"}, 64'(n), 64'd18);
    check({tag, "/dataout"}, 64'(dataout), 64'(exp_data));
    check({tag, "/flags"}, 64'({err_det, err_fix, err_fail}),
          64'({exp_fix | exp_fail, exp_fix, exp_fail}));
    check({tag, "/err_pos"}, 64'(err_pos), 64'(exp_fix ? exp_pos : 4'd0));
    check({tag, "/busy_done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [35:0] info;
    logic [59:0] cw;
    int v, ne;
    int p [3];

    v = 1;
    for (int i = 0; i < 15; i++) begin
      gexp[i] = v; gexp[i+15] = v; glog[v] = i;
      v = v << 1;
      if ((v & 16) != 0) v = v ^ 19;
    end
    glog[0] = 0;
    for (int t = 0; t < 7; t++) gen[t] = 0;
    gen[0] = 1;
    for (int r = 1; r <= 6; r++) begin
      for (int t = r; t >= 1; t--) gen[t] = gen[t-1] ^ gmul(gen[t], gexp[r]);
      gen[0] = gmul(gen[0], gexp[r]);
    end

    rst_n = 1'b0; data_en = 1'b0; codein = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset/outputs", 64'({busy, data_rdy, err_det, err_fix, err_fail, err_pos}), 64'd0);
    check("reset/dataout", 64'(dataout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(60'd0, 36'd0, 1'b0, 1'b0, 4'd0, 0, "clean_zero");
    run({60{1'b1}}, 36'hFFFFFFFFF, 1'b0, 1'b0, 4'd0, 0, "clean_allF");
    run(60'h5 << 40, 36'd0, 1'b1, 1'b0, 4'd10, 0, "single_data");
    cw = encode(36'h123456789);
    run(cw, 36'h123456789, 1'b0, 1'b0, 4'd0, 0, "loop_clean");
    cw[3:0] = cw[3:0] ^ 4'hA;
    run(cw, 36'h123456789, 1'b1, 1'b0, 4'd0, 0, "loop_par0");
    run((60'd1 << 56) | 60'd1, 36'h100000000, 1'b0, 1'b1, 4'd0, 0, "double_fixed");

    for (int d = 0; d < 15; d++) begin
      for (int e = 1; e < 16; e++) begin
        info[31:0]  = $urandom;
        info[35:32] = 4'($urandom);
        cw = encode(info);
        cw[4*d +: 4] = cw[4*d +: 4] ^ 4'(e);
        run(cw, info, 1'b1, 1'b0, 4'(d), 0, "single_sweep");
      end
    end

    for (int k = 0; k < 40; k++) begin
      info[31:0]  = $urandom;
      info[35:32] = 4'($urandom);
      cw = encode(info);
      ne = 2 + (k % 2);
      p[0] = $urandom_range(14, 0);
      do p[1] = $urandom_range(14, 0); while (p[1] == p[0]);
      do p[2] = $urandom_range(14, 0); while (p[2] == p[0] || p[2] == p[1]);
      for (int m = 0; m < ne; m++)
        cw[4*p[m] +: 4] = cw[4*p[m] +: 4] ^ 4'($urandom_range(15, 1));
      run(cw, cw[59:24], 1'b0, 1'b1, 4'd0, 0, "multi_err");
    end

    info = 36'hA5C3E1F07;
    cw = encode(info);
    cw[4*12 +: 4] = cw[4*12 +: 4] ^ 4'h7;
    run(cw, info, 1'b1, 1'b0, 4'd12, 5, "repulse_T5");
    run(encode(36'h0F0F0F0F0), 36'h0F0F0F0F0, 1'b0, 1'b0, 4'd0, 18, "start_at_done");
    @(negedge clk);
    check("start_at_done/ignored", 64'({busy, data_rdy}), 64'b01);

    // Reset at T9 aborts the decode and clears the previous result.
    @(negedge clk);
    codein  = encode(36'h987654321);
    data_en = 1'b1;
    @(negedge clk);
    data_en = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("reset_T9/busy_rdy", 64'({busy, data_rdy}), 64'd0);
    check("reset_T9/dataout", 64'(dataout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("reset_T9/no_result", 64'({busy, data_rdy, err_det}), 64'd0);

    run(encode(36'h13579BDF0), 36'h13579BDF0, 1'b0, 1'b0, 4'd0, 0, "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
